// File: rtl/dsp_pkg.sv
// Shared DSP constants and helpers: sample/coefficient formats, output
// saturation and the quarter-wave sine table generator used by nco_lut.
package dsp_pkg;

  localparam int SAMPLE_W  = 16;
  localparam int COEF_FRAC = 15;
  localparam int ACC_W     = 34;
  localparam int QTR_AW    = 8;
  localparam int QTR_N     = 256;
  localparam int FIX_Q     = 60;
  localparam int FIX_W     = 128;

  localparam logic signed [SAMPLE_W-1:0] PEAK     = 16'sd32767;
  localparam logic signed [SAMPLE_W-1:0] NEG_PEAK = -16'sd32768;
  localparam logic signed [ACC_W-1:0]    RND_HALF = 34'sd16384;
  localparam logic signed [FIX_W-1:0]    FIX_ONE  = 128'sd1 <<< FIX_Q;

  typedef logic [QTR_N-1:0][SAMPLE_W-1:0] qtab_t;

  function automatic logic signed [SAMPLE_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
    if (v > 34'sd32767) begin
      return PEAK;
    end else if (v < -34'sd32768) begin
      return NEG_PEAK;
    end else begin
      return SAMPLE_W'(v);
    end
  endfunction

  // atan(1/n) in Q60, series sum; used only for elaboration-time pi
  function automatic logic signed [FIX_W-1:0] atan_inv(input logic signed [FIX_W-1:0] n);
    logic signed [FIX_W-1:0] pw;
    logic signed [FIX_W-1:0] sum;
    logic signed [FIX_W-1:0] odd;
    pw  = FIX_ONE / n;
    sum = 128'sd0;
    odd = 128'sd1;
    for (int k = 0; k < 40; k++) begin
      if (k[0] == 1'b0) begin
        sum = sum + pw / odd;
      end else begin
        sum = sum - pw / odd;
      end
      pw  = pw / (n * n);
      odd = odd + 128'sd2;
    end
    return sum;
  endfunction

  // round(32767*sin(2*pi*k/1024)) for k = 0..255, exact integer Taylor series
  function automatic qtab_t gen_sine_qtab();
    qtab_t tab;
    logic signed [FIX_W-1:0] pi_q;
    logic signed [FIX_W-1:0] x;
    logic signed [FIX_W-1:0] x2;
    logic signed [FIX_W-1:0] term;
    logic signed [FIX_W-1:0] s;
    logic signed [FIX_W-1:0] n2;
    logic signed [FIX_W-1:0] scaled;
    tab  = '0;
    pi_q = 128'sd16 * atan_inv(128'sd5) - 128'sd4 * atan_inv(128'sd239);
    for (int i = 0; i < QTR_N; i++) begin
      x    = (pi_q * 128'(i)) / 128'sd512;
      x2   = (x * x) >>> FIX_Q;
      term = x;
      s    = x;
      n2   = 128'sd1;
      for (int j = 0; j < 14; j++) begin
        term = (-((term * x2) >>> FIX_Q)) / ((n2 + 128'sd1) * (n2 + 128'sd2));
        s    = s + term;
        n2   = n2 + 128'sd2;
      end
      scaled = (s * 128'sd32767 + (FIX_ONE >>> 1)) >>> FIX_Q;
      tab[i[QTR_AW-1:0]] = SAMPLE_W'(scaled);
    end
    return tab;
  endfunction

endpackage

// File: rtl/nco_lut.sv
// Quarter-wave sine/cosine ROM with symmetry folding; registered sin and cos
// for a full-cycle address, one cycle of latency.
module nco_lut
  import dsp_pkg::*;
#(
  parameter int LUT_AW = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [LUT_AW-1:0]          addr,
  output logic signed [SAMPLE_W-1:0] sin_val,
  output logic signed [SAMPLE_W-1:0] cos_val
);

  localparam qtab_t QTAB = gen_sine_qtab();
  localparam logic [LUT_AW-1:0] QUARTER = {2'b01, {(LUT_AW-2){1'b0}}};

  logic [LUT_AW-1:0] cos_addr_s;

  // Odd quadrants read mirrored; index 0 of a mirrored quadrant is the peak, not in the table
  function automatic logic signed [SAMPLE_W-1:0] fold(input logic [LUT_AW-1:0] a);
    logic [QTR_AW-1:0]          idx;
    logic signed [SAMPLE_W-1:0] mag;
    idx = a[LUT_AW-3 -: QTR_AW];
    if (!a[LUT_AW-2]) begin
      mag = QTAB[idx];
    end else if (idx == {QTR_AW{1'b0}}) begin
      mag = PEAK;
    end else begin
      mag = QTAB[{QTR_AW{1'b0}} - idx];
    end
    if (a[LUT_AW-1]) begin
      return -mag;
    end else begin
      return mag;
    end
  endfunction

  assign cos_addr_s = addr + QUARTER;

  // Registered table outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sin_val <= 16'sd0;
      cos_val <= 16'sd0;
    end else begin
      sin_val <= fold(addr);
      cos_val <= fold(cos_addr_s);
    end
  end

endmodule

// File: rtl/ssb_mixer.sv
// Single-sideband mixer: NCO-driven complex rotation of a Hilbert pair,
// four-stage pipeline with a valid bit per stage.
module ssb_mixer
  import dsp_pkg::*;
#(
  parameter int PHASE_W = 24,
  parameter int LUT_AW  = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cke,
  input  logic signed [SAMPLE_W-1:0] din_re,
  input  logic signed [SAMPLE_W-1:0] din_im,
  input  logic [PHASE_W-1:0]         fcw,
  input  logic                       sel_lsb,
  input  logic                       phase_clr,
  output logic signed [SAMPLE_W-1:0] dout,
  output logic                       cke_out
);

  localparam int PROD_W = 2 * SAMPLE_W;

  logic [PHASE_W-1:0]         phase_acc_r;
  logic                       s1_valid_r;
  logic signed [SAMPLE_W-1:0] s1_re_r;
  logic signed [SAMPLE_W-1:0] s1_im_r;
  logic                       s1_lsb_r;
  logic [LUT_AW-1:0]          s1_addr_r;

  logic                       s2_valid_r;
  logic signed [SAMPLE_W-1:0] s2_re_r;
  logic signed [SAMPLE_W-1:0] s2_im_r;
  logic                       s2_lsb_r;
  logic signed [SAMPLE_W-1:0] lut_sin_s;
  logic signed [SAMPLE_W-1:0] lut_cos_s;

  logic                       s3_valid_r;
  logic                       s3_lsb_r;
  logic signed [PROD_W-1:0]   s3_prod_c_r;
  logic signed [PROD_W-1:0]   s3_prod_s_r;

  logic signed [ACC_W-1:0]    sum_s;
  logic signed [ACC_W-1:0]    rnd_s;

  // S1: sample capture; a sample sees the phase from before its own increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_acc_r <= {PHASE_W{1'b0}};
      s1_valid_r  <= 1'b0;
      s1_re_r     <= 16'sd0;
      s1_im_r     <= 16'sd0;
      s1_lsb_r    <= 1'b0;
      s1_addr_r   <= {LUT_AW{1'b0}};
    end else begin
      s1_valid_r <= cke;
      if (cke) begin
        s1_re_r   <= din_re;
        s1_im_r   <= din_im;
        s1_lsb_r  <= sel_lsb;
        s1_addr_r <= phase_clr ? {LUT_AW{1'b0}} : phase_acc_r[PHASE_W-1 -: LUT_AW];
      end
      if (phase_clr) begin
        phase_acc_r <= cke ? fcw : {PHASE_W{1'b0}};
      end else if (cke) begin
        phase_acc_r <= phase_acc_r + fcw;
      end
    end
  end

  nco_lut #(
    .LUT_AW (LUT_AW)
  ) u_lut (
    .clk     (clk),
    .rst     (rst),
    .addr    (s1_addr_r),
    .sin_val (lut_sin_s),
    .cos_val (lut_cos_s)
  );

  // S2: align the sample with the table read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_r <= 1'b0;
      s2_re_r    <= 16'sd0;
      s2_im_r    <= 16'sd0;
      s2_lsb_r   <= 1'b0;
    end else begin
      s2_valid_r <= s1_valid_r;
      s2_re_r    <= s1_re_r;
      s2_im_r    <= s1_im_r;
      s2_lsb_r   <= s1_lsb_r;
    end
  end

  // S3: products
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_valid_r  <= 1'b0;
      s3_lsb_r    <= 1'b0;
      s3_prod_c_r <= 32'sd0;
      s3_prod_s_r <= 32'sd0;
    end else begin
      s3_valid_r  <= s2_valid_r;
      s3_lsb_r    <= s2_lsb_r;
      s3_prod_c_r <= s2_re_r * lut_cos_s;
      s3_prod_s_r <= s2_im_r * lut_sin_s;
    end
  end

  // Sideband sum and round-half-up to Q0
  always_comb begin
    sum_s = {ACC_W{1'b0}};
    if (s3_lsb_r) begin
      sum_s = {{(ACC_W-PROD_W){s3_prod_c_r[PROD_W-1]}}, s3_prod_c_r}
            + {{(ACC_W-PROD_W){s3_prod_s_r[PROD_W-1]}}, s3_prod_s_r};
    end else begin
      sum_s = {{(ACC_W-PROD_W){s3_prod_c_r[PROD_W-1]}}, s3_prod_c_r}
            - {{(ACC_W-PROD_W){s3_prod_s_r[PROD_W-1]}}, s3_prod_s_r};
    end
    rnd_s = (sum_s + RND_HALF) >>> COEF_FRAC;
  end

  // S4: output register holds between strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout    <= 16'sd0;
      cke_out <= 1'b0;
    end else begin
      cke_out <= s3_valid_r;
      if (s3_valid_r) begin
        dout <= saturate(rnd_s);
      end
    end
  end

endmodule

// File: tb/tb_ssb_mixer.sv
// Self-checking bench for ssb_mixer: directed cases plus randomized traffic
// against a real-arithmetic reference model with an expected-output queue.
module tb_ssb_mixer;

  localparam int PHASE_W = 24;
  localparam int LUT_AW  = 10;

  logic               clk = 1'b0;
  logic               rst;
  logic               cke;
  logic signed [15:0] din_re;
  logic signed [15:0] din_im;
  logic [PHASE_W-1:0] fcw;
  logic               sel_lsb;
  logic               phase_clr;
  logic signed [15:0] dout;
  logic               cke_out;

  int     checks = 0;
  int     failures = 0;
  int     cyc = 0;
  int     c0;
  int     last_dout = 0;
  longint acc_m = 0;
  int     exp_due[$];
  int     exp_val[$];
  int     plog_val[$];
  int     plog_cyc[$];

  ssb_mixer #(.PHASE_W(PHASE_W), .LUT_AW(LUT_AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cke       (cke),
    .din_re    (din_re),
    .din_im    (din_im),
    .fcw       (fcw),
    .sel_lsb   (sel_lsb),
    .phase_clr (phase_clr),
    .dout      (dout),
    .cke_out   (cke_out)
  );

  initial forever #5 clk = ~clk;

  function automatic int ref_sin(input int k);
    real v;
    v = 32767.0 * $sin(2.0 * 3.14159265358979323846 * real'(k) / 1024.0);
    return $rtoi($floor(v + 0.5));
  endfunction

  function automatic int ref_mix(input longint ph, input int re, input int im, input bit lsb);
    int     k;
    longint a;
    longint r;
    longint q;
    k = int'(ph >> (PHASE_W - LUT_AW));
    if (lsb) a = longint'(re) * ref_sin((k + 256) % 1024) + longint'(im) * ref_sin(k);
    else     a = longint'(re) * ref_sin((k + 256) % 1024) - longint'(im) * ref_sin(k);
    r = a + 16384;
    if (r >= 0) q = r / 32768;
    else        q = -((-r + 32767) / 32768);
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
    return int'(q);
  endfunction

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // One clock: model the edge, then compare outputs on the falling edge
  task automatic step();
    longint ph;
    bit     exp_v;
    @(posedge clk);
    cyc++;
    if (rst) begin
      exp_due.delete();
      exp_val.delete();
      acc_m = 0;
      last_dout = 0;
    end else begin
      if (cke) begin
        ph = phase_clr ? 0 : acc_m;
        exp_due.push_back(cyc + 3);
        exp_val.push_back(ref_mix(ph, int'(din_re), int'(din_im), sel_lsb));
      end
      if (phase_clr) acc_m = cke ? longint'(fcw) : 0;
      else if (cke) acc_m = (acc_m + longint'(fcw)) % 64'sd16777216;
    end
    @(negedge clk);
    exp_v = 1'b0;
    if (exp_due.size() > 0 && exp_due[0] == cyc) begin
      exp_v = 1'b1;
      last_dout = exp_val.pop_front();
      void'(exp_due.pop_front());
    end
    if (cke_out === 1'b1) begin
      plog_val.push_back(int'(dout));
      plog_cyc.push_back(cyc);
    end
    check("cke_out", cke_out, exp_v);
    check("dout", dout, last_dout);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cke = 1'b0;
    phase_clr = 1'b0;
    step();
    step();
    check("rst_dout", dout, 0);
    check("rst_cke_out", cke_out, 0);
    rst = 1'b0;
    plog_val.delete();
    plog_cyc.delete();
  endtask

  initial begin
    rst = 1'b1; cke = 1'b0; din_re = 16'sd0; din_im = 16'sd0;
    fcw = '0; sel_lsb = 1'b0; phase_clr = 1'b0;
    do_reset();

    // single sample, zero frequency
    fcw = 24'd0; din_re = 16'sd16384; din_im = 16'sd0; sel_lsb = 1'b0;
    c0 = cyc; cke = 1'b1; step(); cke = 1'b0;
    repeat (6) step();
    check("r031_count", plog_val.size(), 1);
    check("r031_dout", plog_val[0], 16384);
    check("r031_latency", plog_cyc[0] - c0, 4);

    // half-rate rotation, continuous strobe
    do_reset();
    fcw = 24'h800000; din_re = 16'sd16384; din_im = 16'sd0;
    cke = 1'b1; repeat (8) step(); cke = 1'b0;
    repeat (6) step();
    check("r032_count", plog_val.size(), 8);
    for (int i = 0; i < 8; i++)
      check($sformatf("r032_p%0d", i), plog_val[i], (i % 2 == 0) ? 16384 : -16383);

    // 45 degree point, both sidebands
    for (int sb = 0; sb < 2; sb++) begin
      do_reset();
      fcw = 24'h200000; din_re = -16'sd32768; din_im = 16'sd32767; sel_lsb = sb[0];
      cke = 1'b1; repeat (2) step(); cke = 1'b0;
      repeat (6) step();
      check("r033_count", plog_val.size(), 2);
      check(sb == 0 ? "r033_usb_sat" : "r034_lsb", plog_val[1], sb == 0 ? -32768 : -1);
    end
    sel_lsb = 1'b0;

    // reset with samples in flight
    do_reset();
    fcw = 24'h0A5A5A;
    cke = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din_re = 16'($urandom); din_im = 16'($urandom); step();
    end
    cke = 1'b0; rst = 1'b1;
    step(); step();
    rst = 1'b0;
    repeat (8) step();
    check("r036_quiet", plog_val.size(), 0);
    din_re = 16'sd12345; din_im = -16'sd777;
    c0 = cyc; cke = 1'b1; step(); cke = 1'b0;
    repeat (6) step();
    check("r036_count", plog_val.size(), 1);
    check("r036_latency", plog_cyc[0] - c0, 4);
    check("r036_dout", plog_val[0], 12345);

    // randomized traffic: bursty, continuous and sparse strobes
    do_reset();
    fcw = 24'($urandom);
    for (int blk = 0; blk < 15; blk++) begin
      for (int i = 0; i < 200; i++) begin
        case (blk % 3)
          0:       cke = 1'b1;
          1:       cke = ($urandom_range(0, 3) != 0);
          default: cke = ($urandom_range(0, 7) == 0);
        endcase
        din_re = ($urandom_range(0, 15) == 0) ? -16'sd32768 : 16'($urandom);
        din_im = ($urandom_range(0, 15) == 0) ? 16'sd32767 : 16'($urandom);
        if ($urandom_range(0, 49) == 0) fcw = 24'($urandom);
        if ($urandom_range(0, 19) == 0) sel_lsb = ~sel_lsb;
        phase_clr = ($urandom_range(0, 99) == 0);
        step();
      end
    end
    cke = 1'b0; phase_clr = 1'b0;
    repeat (6) step();

    // long sweep through address wrap, then clear together with a sample
    do_reset();
    fcw = 24'h000100; sel_lsb = 1'b0; cke = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      din_re = 16'($urandom); din_im = 16'($urandom);
      step();
    end
    phase_clr = 1'b1; din_re = 16'sd16384; din_im = 16'sd9999;
    step();
    phase_clr = 1'b0; cke = 1'b0;
    repeat (6) step();
    check("r035_clr_dout", plog_val[plog_val.size() - 1], 16384);
    check("r035_count", plog_val.size(), 70001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
